// File: rtl/servo_pkg.sv
// Shared types and constants for the servo PWM controller.
package servo_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LOAD = 2'd2
  } servo_state_t;

  localparam logic [7:0] CENTER_X = 8'd128;
  localparam logic [6:0] CENTER_Y = 7'd64;

endpackage

// File: rtl/servo_slew.sv
// One axis of position slewing: moves pos toward tgt by at most
// SLEW_LSB, landing exactly on tgt when it is closer than that.
module servo_slew
  import servo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int SLEW_LSB = 4
) (
  input  logic [WIDTH-1:0] pos,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] next_pos
);

  localparam logic [31:0] SLEW_U = SLEW_LSB;

  logic [WIDTH-1:0] diff;

  // Clamp the step to the remaining distance so neither end can wrap.
  always_comb begin
    next_pos = pos;
    diff     = '0;
    if (tgt > pos) begin
      diff = tgt - pos;
      if (32'(diff) > SLEW_U) next_pos = pos + WIDTH'(SLEW_U);
      else                    next_pos = tgt;
    end else if (tgt < pos) begin
      diff = pos - tgt;
      if (32'(diff) > SLEW_U) next_pos = pos - WIDTH'(SLEW_U);
      else                    next_pos = tgt;
    end
  end

endmodule

// File: rtl/servo_pwm_ctrl.sv
// Two-axis servo PWM controller with per-period slew limiting.
// Optional command watchdog is built in when SERVO_WDT_EN is defined.
module servo_pwm_ctrl
  import servo_pkg::*;
#(
  parameter int PERIOD_CYC  = 2_000_000,
  parameter int MIN_CYC     = 100_000,
  parameter int STEP_X_CYC  = 392,
  parameter int STEP_Y_CYC  = 787,
  parameter int SLEW_LSB    = 4,
  parameter int WDT_PERIODS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_xdata,
  input  logic [6:0] cmd_ydata,
  output logic       pwm_x,
  output logic       pwm_y,
  output logic [7:0] pos_x,
  output logic [6:0] pos_y,
  output logic       at_target,
  output logic       wdt_fault
);

  // The counter reaches PERIOD_CYC for one cycle (during S_LOAD).
  localparam int CNT_W = $clog2(PERIOD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);
  // Pulse widths are compared at 32 bits, wider than any period count.
  localparam logic [31:0] MIN_U   = MIN_CYC;
  localparam logic [31:0] STEPX_U = STEP_X_CYC;
  localparam logic [31:0] STEPY_U = STEP_Y_CYC;

  servo_state_t     state;
  servo_state_t     next_state;
  logic             in_run;
  logic             in_load;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       tgt_x;
  logic [6:0]       tgt_y;
  logic [7:0]       slew_x;
  logic [6:0]       slew_y;
  logic [31:0]      width_x;
  logic [31:0]      width_y;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; dropping enable always parks the FSM in idle.
  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  next_state = S_RUN;
        S_RUN:   if (cnt == CNT_LAST) next_state = S_LOAD;
        S_LOAD:  next_state = S_RUN;
        default: next_state = S_IDLE;
      endcase
    end
  end

  // State decode used by the datapath.
  always_comb begin
    in_run  = (state == S_RUN);
    in_load = (state == S_LOAD);
  end

  // Period counter: counts while running, zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (in_run && enable) cnt <= cnt + CNT_W'(1);
    else                       cnt <= '0;
  end

  assign width_x = MIN_U + {24'd0, pos_x} * STEPX_U;
  assign width_y = MIN_U + {25'd0, pos_y} * STEPY_U;

  // Registered pulse outputs; async reset drops them immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_x <= 1'b0;
      pwm_y <= 1'b0;
    end else begin
      pwm_x <= in_run && (32'(cnt) < width_x);
      pwm_y <= in_run && (32'(cnt) < width_y);
    end
  end

  servo_slew #(.WIDTH(8), .SLEW_LSB(SLEW_LSB)) u_slew_x (
    .pos      (pos_x),
    .tgt      (tgt_x),
    .next_pos (slew_x)
  );

  servo_slew #(.WIDTH(7), .SLEW_LSB(SLEW_LSB)) u_slew_y (
    .pos      (pos_y),
    .tgt      (tgt_y),
    .next_pos (slew_y)
  );

  // Positions move only at the period boundary so a pulse never changes mid-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x <= CENTER_X;
      pos_y <= CENTER_Y;
    end else if (in_load) begin
      pos_x <= slew_x;
      pos_y <= slew_y;
    end
  end

`ifdef SERVO_WDT_EN
  localparam int WDT_W = $clog2(WDT_PERIODS + 1);
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_PERIODS);
  localparam logic [31:0]      WDT_U   = WDT_PERIODS;

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_fault_q;
  logic             wdt_expire;

  assign wdt_expire = in_load && ((32'(wdt_cnt) + 32'd1) >= WDT_U);

  // Count period boundaries without a command; a command always wins over expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdt_cnt     <= '0;
      wdt_fault_q <= 1'b0;
    end else if (cmd_valid) begin
      wdt_cnt     <= '0;
      wdt_fault_q <= 1'b0;
    end else if (in_load) begin
      if (wdt_cnt != WDT_MAX) wdt_cnt <= wdt_cnt + WDT_W'(1);
      if (wdt_expire)         wdt_fault_q <= 1'b1;
    end
  end

  // Target latch; on expiry the target falls back to centre until the next command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_x <= CENTER_X;
      tgt_y <= CENTER_Y;
    end else if (cmd_valid) begin
      tgt_x <= cmd_xdata;
      tgt_y <= cmd_ydata;
    end else if (wdt_expire) begin
      tgt_x <= CENTER_X;
      tgt_y <= CENTER_Y;
    end
  end

  assign wdt_fault = wdt_fault_q;
`else
  // Target latch; commands are accepted in every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_x <= CENTER_X;
      tgt_y <= CENTER_Y;
    end else if (cmd_valid) begin
      tgt_x <= cmd_xdata;
      tgt_y <= cmd_ydata;
    end
  end

  assign wdt_fault = 1'b0;
`endif

  assign at_target = (pos_x == tgt_x) && (pos_y == tgt_y);

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Bench for servo_pwm_ctrl with a reduced period; honours SERVO_WDT_EN.
module tb_servo_pwm_ctrl;

  localparam int PERIOD_CYC  = 1000;
  localparam int MIN_CYC     = 100;
  localparam int STEP_X_CYC  = 1;
  localparam int STEP_Y_CYC  = 2;
  localparam int SLEW_LSB    = 4;
  localparam int WDT_PERIODS = 3;
  localparam int FRAME       = PERIOD_CYC + 1;
`ifdef SERVO_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_xdata = 8'd0;
  logic [6:0] cmd_ydata = 7'd0;
  logic       pwm_x, pwm_y, at_target, wdt_fault;
  logic [7:0] pos_x;
  logic [6:0] pos_y;

  int test_count = 0;
  int fail_count = 0;
  bit check_en = 1'b0;

  // Expected controller state.
  int m_pos_x = 128, m_pos_y = 64, m_tgt_x = 128, m_tgt_y = 64;
  int m_en_count = 0, m_wdt_cnt = 0;
  bit m_pwm_x = 1'b0, m_pwm_y = 1'b0, m_fault = 1'b0;

  servo_pwm_ctrl #(
    .PERIOD_CYC(PERIOD_CYC), .MIN_CYC(MIN_CYC), .STEP_X_CYC(STEP_X_CYC),
    .STEP_Y_CYC(STEP_Y_CYC), .SLEW_LSB(SLEW_LSB), .WDT_PERIODS(WDT_PERIODS)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_xdata(cmd_xdata), .cmd_ydata(cmd_ydata), .pwm_x(pwm_x), .pwm_y(pwm_y),
    .pos_x(pos_x), .pos_y(pos_y), .at_target(at_target), .wdt_fault(wdt_fault)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    test_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic apply_stimulus(input bit valid, input int x, input int y);
    cmd_valid = valid;
    cmd_xdata = 8'(x);
    cmd_ydata = 7'(y);
  endtask

  function automatic int toward(input int p, input int t);
    int d;
    d = t - p;
    if (d > SLEW_LSB) d = SLEW_LSB;
    else if (d < -SLEW_LSB) d = -SLEW_LSB;
    return p + d;
  endfunction

  task automatic model_reset();
    m_pos_x = 128; m_pos_y = 64; m_tgt_x = 128; m_tgt_y = 64;
    m_en_count = 0; m_wdt_cnt = 0;
    m_pwm_x = 1'b0; m_pwm_y = 1'b0; m_fault = 1'b0;
  endtask

  // Each enabled run is a sequence of frames of PERIOD_CYC counting cycles
  // followed by one boundary cycle; phase is the position inside the frame.
  task automatic model_step();
    int  phase;
    bit  boundary;
    phase    = (m_en_count == 0) ? -1 : (m_en_count - 1) % FRAME;
    boundary = (phase == PERIOD_CYC);
    m_pwm_x  = (phase >= 0) && (phase < PERIOD_CYC) && (phase < MIN_CYC + m_pos_x * STEP_X_CYC);
    m_pwm_y  = (phase >= 0) && (phase < PERIOD_CYC) && (phase < MIN_CYC + m_pos_y * STEP_Y_CYC);
    if (boundary) begin
      m_pos_x = toward(m_pos_x, m_tgt_x);
      m_pos_y = toward(m_pos_y, m_tgt_y);
    end
    if (WDT_ON) begin
      if (cmd_valid) begin
        m_wdt_cnt = 0;
        m_fault   = 1'b0;
      end else if (boundary) begin
        m_wdt_cnt++;
        if (m_wdt_cnt >= WDT_PERIODS) begin
          m_fault = 1'b1;
          m_tgt_x = 128;
          m_tgt_y = 64;
        end
      end
    end
    if (cmd_valid) begin
      m_tgt_x = cmd_xdata;
      m_tgt_y = cmd_ydata;
    end
    m_en_count = enable ? m_en_count + 1 : 0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // Cycle-by-cycle comparison against the expected state.
  always @(negedge clk) begin
    if (check_en && fail_count < 50) begin
      check_output("pwm_x", pwm_x, m_pwm_x);
      check_output("pwm_y", pwm_y, m_pwm_y);
      check_output("pos_x", pos_x, m_pos_x);
      check_output("pos_y", pos_y, m_pos_y);
      check_output("at_target", at_target, (m_pos_x == m_tgt_x) && (m_pos_y == m_tgt_y));
      check_output("wdt_fault", wdt_fault, m_fault);
    end
  end

  task automatic start_run();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
  endtask

  // One full frame, counting high cycles of each pulse; optional command at index idx.
  task automatic run_period(input bit send, input int idx, input int x, input int y,
                            output int wx, output int wy);
    wx = 0;
    wy = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (pwm_x) wx++;
      if (pwm_y) wy++;
      if (send && i == idx) apply_stimulus(1'b1, x, y);
      else if (cmd_valid)   apply_stimulus(1'b0, 0, 0);
    end
    if (cmd_valid) apply_stimulus(1'b0, 0, 0);
  endtask

  initial begin
    int wx, wy, off_left;
    off_left = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_en = 1'b1;
    check_output("reset_pwm_x", pwm_x, 0);
    check_output("reset_pwm_y", pwm_y, 0);
    check_output("reset_pos_x", pos_x, 128);
    check_output("reset_pos_y", pos_y, 64);
    check_output("reset_at_target", at_target, 1);

    // Centre position with no command.
    start_run();
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("centre_width_x", wx, 228);
    check_output("centre_width_y", wy, 228);
    check_output("centre_at_target", at_target, 1);

    // Slew toward x=140.
    run_period(1'b1, 0, 140, 64, wx, wy);
    check_output("slew1_width_x", wx, 228);
    check_output("slew1_pos_x", pos_x, 132);
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("slew2_width_x", wx, 232);
    check_output("slew2_pos_x", pos_x, 136);
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("slew3_width_x", wx, 236);
    check_output("slew3_pos_x", pos_x, 140);
    check_output("slew3_pos_y", pos_y, 64);
    check_output("slew3_wdt_fault", wdt_fault, WDT_ON);

    // Asynchronous reset in the middle of a 240-cycle pulse.
    repeat (50) @(negedge clk);
    @(posedge clk);
    #2;
    check_output("pre_reset_pwm_x", pwm_x, 1);
    reset = 1'b1;
    #1;
    check_output("async_reset_pwm_x", pwm_x, 0);
    check_output("async_reset_pwm_y", pwm_y, 0);
    check_output("async_reset_pos_x", pos_x, 128);
    check_output("async_reset_pos_y", pos_y, 64);
    check_output("async_reset_at_target", at_target, 1);
    check_output("async_reset_wdt_fault", wdt_fault, 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Drive to the low x end and high y end.
    start_run();
    for (int p = 0; p < 32; p++) run_period(1'b1, 0, 2, 125, wx, wy);
    check_output("near_end_pos_x", pos_x, 2);
    check_output("near_end_pos_y", pos_y, 125);
    run_period(1'b1, 0, 0, 127, wx, wy);
    check_output("near_end_width_x", wx, 102);
    check_output("near_end_width_y", wy, 350);
    check_output("end_pos_x", pos_x, 0);
    check_output("end_pos_y", pos_y, 127);
    run_period(1'b1, 0, 0, 127, wx, wy);
    check_output("end_width_x", wx, 100);
    check_output("end_width_y", wy, 354);
    check_output("end_hold_pos_x", pos_x, 0);
    check_output("end_at_target", at_target, 1);

    // Command on the boundary cycle lands one period later.
    run_period(1'b1, FRAME - 2, 8, 127, wx, wy);
    check_output("late_cmd_pos_x", pos_x, 0);
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("late_cmd_next_pos_x", pos_x, 4);
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("late_cmd_final_pos_x", pos_x, 8);

    // Command starvation.
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("starve_wdt_fault", wdt_fault, WDT_ON);
    check_output("starve_pos_x", pos_x, 8);
    run_period(1'b0, 0, 0, 0, wx, wy);
    check_output("starve_return_pos_x", pos_x, WDT_ON ? 12 : 8);
    check_output("starve_return_pos_y", pos_y, WDT_ON ? 123 : 127);
    run_period(1'b1, 0, 8, 127, wx, wy);
    check_output("recover_wdt_fault", wdt_fault, 0);
    check_output("recover_pos_x", pos_x, 8);
    check_output("recover_pos_y", pos_y, 127);

    // Random commands and enable drops.
    @(negedge clk);
    enable = 1'b0;
    repeat (7) @(negedge clk);
    enable = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (off_left > 0) begin
        off_left--;
        if (off_left == 0) enable = 1'b1;
      end else if ($urandom_range(0, 2999) == 0) begin
        enable   = 1'b0;
        off_left = int'($urandom_range(1, 20));
      end
      if ($urandom_range(0, 399) == 0)
        apply_stimulus(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 127)));
      else if (cmd_valid)
        apply_stimulus(1'b0, 0, 0);
    end
    @(negedge clk);
    check_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
